// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: walks NEURONS lookups of one shared truth-table memory per input vector.
// Optional LAYER_SEQ_PERF_EN adds perf_stall / perf_vecs counters.
module layer_seq_ctrl #(
  parameter int unsigned NEURONS  = 16,
  parameter int unsigned IN_WIDTH = 64,
  parameter int unsigned FANIN    = 6,
  parameter int unsigned OUT_BITS = 2,
  // A single neuron still gets a 1-bit index so the ports keep a legal width
  localparam int unsigned IdxW    = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in_data,
  output logic [IN_WIDTH-1:0]          act_vec,
  output logic [IdxW-1:0]              gather_idx,
  input  logic [FANIN-1:0]             gather_bits,
  output logic [IdxW+FANIN-1:0]        mem_addr,
  output logic                         mem_en,
  input  logic [OUT_BITS-1:0]          mem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]                  perf_stall,
  output logic [31:0]                  perf_vecs
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NEURONS - 1);

  state_e                        state_q, state_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic [IN_WIDTH-1:0]           act_q, act_d;
  logic                          rd_pend_q, rd_pend_d;
  logic [IdxW-1:0]               rd_idx_q, rd_idx_d;
  logic [NEURONS*OUT_BITS-1:0]   res_q, res_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    act_d     = act_q;
    res_d     = res_q;
    rd_pend_d = 1'b0;
    rd_idx_d  = rd_idx_q;
    in_ready  = 1'b0;
    mem_en    = 1'b0;
    out_valid = 1'b0;

    // Read data returns one cycle after issue; land it in the slot it was issued for
    for (int unsigned k = 0; k < NEURONS; k++) begin
      if (rd_pend_q && (rd_idx_q == IdxW'(k))) begin
        res_d[k*OUT_BITS +: OUT_BITS] = mem_rdata;
      end
    end

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          act_d   = in_data;
          idx_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        mem_en    = 1'b1;
        rd_pend_d = 1'b1;
        rd_idx_d  = idx_q;
        // Index parks at the last neuron instead of wrapping
        if (idx_q == LastIdx) begin
          state_d = StDrain;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      act_q     <= '0;
      res_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      res_q     <= res_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  assign act_vec    = act_q;
  assign gather_idx = idx_q;
  assign mem_addr   = {idx_q, gather_bits};
  assign out_data   = res_q;

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] vecs_q, vecs_d;

  always_comb begin
    stall_d = stall_q;
    vecs_d  = vecs_q;
    if (state_q == StDone) begin
      if (out_ready) begin
        vecs_d = vecs_q + 32'd1;
      end else begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      vecs_q  <= '0;
    end else begin
      stall_q <= stall_d;
      vecs_q  <= vecs_d;
    end
  end

  assign perf_stall = stall_q;
  assign perf_vecs  = vecs_q;
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: 16-neuron instance plus a 1-neuron corner instance.
module tb_layer_seq_ctrl;
  localparam int N    = 16;
  localparam int IW   = 64;
  localparam int FI   = 6;
  localparam int OB   = 2;
  localparam int IdxW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                in_valid, in_ready;
  logic [IW-1:0]       in_data, act_vec;
  logic [IdxW-1:0]     gather_idx;
  logic [FI-1:0]       gather_bits;
  logic [IdxW+FI-1:0]  mem_addr;
  logic                mem_en;
  logic [OB-1:0]       mem_rdata;
  logic                out_valid, out_ready;
  logic [N*OB-1:0]     out_data;

  logic                n1_in_valid, n1_in_ready;
  logic [7:0]          n1_in_data, n1_act_vec;
  logic [0:0]          n1_gather_idx;
  logic [3:0]          n1_gather_bits;
  logic [4:0]          n1_mem_addr;
  logic                n1_mem_en;
  logic [1:0]          n1_mem_rdata;
  logic                n1_out_valid, n1_out_ready;
  logic [1:0]          n1_out_data;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]         perf_stall, perf_vecs, n1_perf_stall, n1_perf_vecs;
`endif

  layer_seq_ctrl #(.NEURONS(N), .IN_WIDTH(IW), .FANIN(FI), .OUT_BITS(OB)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .act_vec(act_vec), .gather_idx(gather_idx), .gather_bits(gather_bits),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
`ifdef LAYER_SEQ_PERF_EN
    , .perf_stall(perf_stall), .perf_vecs(perf_vecs)
`endif
  );

  layer_seq_ctrl #(.NEURONS(1), .IN_WIDTH(8), .FANIN(4), .OUT_BITS(2)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .in_data(n1_in_data), .act_vec(n1_act_vec), .gather_idx(n1_gather_idx),
    .gather_bits(n1_gather_bits), .mem_addr(n1_mem_addr), .mem_en(n1_mem_en),
    .mem_rdata(n1_mem_rdata), .out_valid(n1_out_valid), .out_ready(n1_out_ready),
    .out_data(n1_out_data)
`ifdef LAYER_SEQ_PERF_EN
    , .perf_stall(n1_perf_stall), .perf_vecs(n1_perf_vecs)
`endif
  );

  // Fan-in gather: neuron k sees {k[1:0], act[4k+3:4k]}; memory returns addr[1:0]
  assign gather_bits    = {gather_idx[1:0], act_vec[gather_idx*4 +: 4]};
  assign n1_gather_bits = n1_act_vec[3:0];
  always @(posedge clk) begin
    mem_rdata    <= mem_addr[1:0];
    n1_mem_rdata <= n1_mem_addr[1:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*OB-1:0] model(input logic [IW-1:0] d);
    logic [N*OB-1:0] r;
    for (int k = 0; k < N; k++) r[k*OB +: OB] = d[k*4 +: 2];
    return r;
  endfunction

  // Scoreboard: push on observed input handshake
  logic [N*OB-1:0] exp_q[$];
  int              acc_q[$];
  bit              spacing_on = 1'b0;
  int              last_acc = -1;

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(in_data));
      acc_q.push_back(cyc);
      if (spacing_on && last_acc >= 0) check("accept_spacing", 64'(cyc - last_acc), 64'd19);
      last_acc = cyc;
    end
  end

  // Monitor: pop on each new result, then hold-check while out_valid stays up
  bit              prev_v = 1'b0;
  logic [N*OB-1:0] hold;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid: got out_data %0h expected no result", out_data);
          end else begin
            logic [N*OB-1:0] e;
            int              a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("out_data", 64'(out_data), 64'(e));
            check("latency", 64'(cyc - a), 64'd18);
          end
          hold = out_data;
        end else begin
          check("out_data_stable", 64'(out_data), 64'(hold));
        end
        check("in_ready_in_done", 64'(in_ready), 64'd0);
      end
      prev_v = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [IW-1:0] d);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] vecs [4];
    int            n, acc1, en_cnt;
    vecs[0] = 64'h1111_2222_3333_4444;
    vecs[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    vecs[2] = 64'h7E57_C0DE_1234_8765;
    vecs[3] = 64'h0;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    n1_in_valid = 1'b0; n1_in_data = '0; n1_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_act_vec", act_vec, 64'd0);
    check("rst_gather_idx", 64'(gather_idx), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single vector, out_ready high
    send(64'h0123_4567_89AB_CDEF);
    wait_idle();

    // Back-pressure: 5 DONE cycles with out_ready low
    out_ready = 1'b0;
    send(64'hFEDC_BA98_7654_3210);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_done", 64'(out_valid), 64'd1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
`ifdef LAYER_SEQ_PERF_EN
    check("perf_stall", 64'(perf_stall), 64'd5);
`endif

    // in_valid held continuously: accepts 19 cycles apart
    last_acc   = -1;
    spacing_on = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = vecs[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) check("stream_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_data = vecs[i+1];
      if (i == 2) in_valid = 1'b0;
    end
    wait_idle();
    spacing_on = 1'b0;
`ifdef LAYER_SEQ_PERF_EN
    check("perf_vecs", 64'(perf_vecs), 64'd5);
`endif

    // Stray in_valid mid-RUN must be ignored
    send(64'h3C3C_9696_C3C3_6969);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b1; in_data = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    check("act_vec_hold", act_vec, 64'h3C3C_9696_C3C3_6969);
    wait_idle();

    // Reset while neuron 7 is being issued
    send(64'hDEAD_BEEF_CAFE_F00D);
    n = 0;
    @(negedge clk);
    while (!(mem_en && gather_idx == 4'd6) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx6", 64'(gather_idx), 64'd6);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("abort_idx7", 64'(gather_idx), 64'd7);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_mem_en", 64'(mem_en), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
`ifdef LAYER_SEQ_PERF_EN
    check("abort_perf_vecs", 64'(perf_vecs), 64'd0);
`endif
    repeat (25) @(negedge clk);
    send(64'h8642_0BDF_1357_9ACE);
    wait_idle();

    // Single-neuron instance: 3-cycle latency, one read strobe
    @(posedge clk); #1;
    n1_in_valid = 1'b1;
    n1_in_data  = 8'hA7;
    @(negedge clk);
    check("n1_in_ready", 64'(n1_in_ready), 64'd1);
    acc1 = cyc;
    @(posedge clk); #1 n1_in_valid = 1'b0; n1_in_data = 8'h00;
    en_cnt = 0;
    n = 0;
    @(negedge clk);
    while (!n1_out_valid && n < 10) begin
      if (n1_mem_en) en_cnt++;
      @(negedge clk);
      n++;
    end
    check("n1_latency", 64'(cyc - acc1), 64'd3);
    check("n1_out_data", 64'(n1_out_data), 64'd3);
    repeat (3) begin
      @(negedge clk);
      if (n1_mem_en) en_cnt++;
    end
    check("n1_mem_en_cycles", 64'(en_cnt), 64'd1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
